// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : framed byte-stream boot loader for instruction memory
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module imem_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int IMEM_DEPTH    = 1024,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     imem_we,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]    imem_wdata,
  output logic                     cpu_rst,
  output logic                     done,
  output logic                     error,
  output logic [15:0]              words_loaded
);

  localparam logic [2:0] c_st_len_lo = 3'd0;
  localparam logic [2:0] c_st_len_hi = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_csum   = 3'd3;
  localparam logic [2:0] c_st_run    = 3'd4;
  localparam logic [2:0] c_st_err    = 3'd5;

  localparam logic [16:0] c_depth = 17'(IMEM_DEPTH);

  logic [2:0]               r_state;
  logic [2:0]               w_state_next;
  logic [1:0]               r_lane;
  logic [7:0]               r_xor;
  logic [15:0]              r_len;
  logic [23:0]              r_word;
  logic                     r_we;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [15:0]              r_words_loaded;
  logic                     r_cpu_rst;
  logic                     r_done;
  logic                     r_error;

  logic                     w_accept;
  logic [15:0]              w_len_full;
  logic                     w_last_word;
  logic [ADDRESS_WIDTH-1:0] w_offset;

  assign w_accept    = byte_valid && byte_ready;
  assign w_len_full  = {byte_data, r_len[7:0]};
  // At lane-3 acceptance the counter still holds the count of words before this one.
  assign w_last_word = ((r_words_loaded + 16'd1) == r_len);
  assign w_offset    = ADDRESS_WIDTH'({r_words_loaded, 2'b00});

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_len_lo;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      case (r_state)
        c_st_len_lo: w_state_next = c_st_len_hi;
        c_st_len_hi: begin
          if (w_len_full == 16'd0) begin
            w_state_next = c_st_csum;
          end else if ({1'b0, w_len_full} > c_depth) begin
            w_state_next = c_st_err;
          end else begin
            w_state_next = c_st_data;
          end
        end
        c_st_data: begin
          if ((r_lane == 2'd3) && w_last_word) begin
            w_state_next = c_st_csum;
          end
        end
        c_st_csum: w_state_next = (byte_data == r_xor) ? c_st_run : c_st_err;
        default: w_state_next = r_state;
      endcase
    end
  end

  // Output decode
  always_comb begin
    byte_ready = 1'b0;
    case (r_state)
      c_st_len_lo, c_st_len_hi, c_st_data, c_st_csum: byte_ready = !rst;
      default: byte_ready = 1'b0;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane         <= 2'd0;
      r_xor          <= 8'd0;
      r_len          <= 16'd0;
      r_word         <= 24'd0;
      r_we           <= 1'b0;
      r_addr         <= BASE_ADDR;
      r_wdata        <= '0;
      r_words_loaded <= 16'd0;
      r_cpu_rst      <= 1'b1;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_cpu_rst <= (w_state_next != c_st_run);
      r_done    <= (w_state_next == c_st_run);
      r_error   <= (w_state_next == c_st_err);
      if (w_accept) begin
        case (r_state)
          c_st_len_lo: begin
            r_len[7:0] <= byte_data;
            r_xor      <= r_xor ^ byte_data;
          end
          c_st_len_hi: begin
            r_len[15:8] <= byte_data;
            r_xor       <= r_xor ^ byte_data;
          end
          c_st_data: begin
            r_xor  <= r_xor ^ byte_data;
            r_lane <= r_lane + 2'd1;
            if (r_lane == 2'd3) begin
              r_we           <= 1'b1;
              r_wdata        <= DATA_WIDTH'({byte_data, r_word});
              r_addr         <= BASE_ADDR + w_offset;
              r_words_loaded <= r_words_loaded + 16'd1;
            end else begin
              // Shift in from the top so b0 ends up in the low byte after three lanes.
              r_word <= {byte_data, r_word[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign cpu_rst      = r_cpu_rst;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : directed scoreboard bench for imem_loader
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imem_loader;

  localparam logic [31:0] c_base = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int          checks   = 0;
  int          errors   = 0;
  int          n_writes = 0;
  int          wr_start = 0;
  int          exp_idx  = 0;
  logic [7:0]  tb_xor;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      logic [63:0] e;
      n_writes++;
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", imem_addr, e[63:32]);
        chk("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    byte_valid = 1'b1;
    byte_data  = b;
    tb_xor     = tb_xor ^ b;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'hA5;
    if (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [7:0] bb;
    exp_q.push_back({c_base + 32'(exp_idx) * 32'd4, w});
    exp_idx++;
    for (int i = 0; i < 4; i++) begin
      bb = w[8*i +: 8];
      send_byte(bb, gap);
    end
  endtask

  task automatic frame(input logic [15:0] n, input logic [31:0] w0, input logic [31:0] w1,
                       input bit gap, input logic [7:0] flip);
    logic [7:0] c;
    tb_xor = 8'h00;
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    if (n >= 16'd1) send_word(w0, gap);
    if (n >= 16'd2) send_word(w1, gap);
    c = tb_xor ^ flip;
    send_byte(c, gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_words", words_loaded, 32'd0);
    chk("rst_ready", byte_ready, 1'b0);
    rst      = 1'b0;
    exp_idx  = 0;
    wr_start = n_writes;
    tb_xor   = 8'h00;
    #1;
  endtask

  task automatic check_end(input string tag, input bit ok, input int nwords, input int nwr);
    chk({tag, "_cpu_rst"}, cpu_rst, 32'(!ok));
    chk({tag, "_done"}, done, 32'(ok));
    chk({tag, "_error"}, error, 32'(!ok));
    chk({tag, "_ready"}, byte_ready, 1'b0);
    chk({tag, "_words"}, words_loaded, 32'(nwords));
    chk({tag, "_writes"}, 32'(n_writes - wr_start), 32'(nwr));
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    tb_xor     = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_cpu_rst", cpu_rst, 1'b1);
    chk("reset_done", done, 1'b0);
    chk("reset_error", error, 1'b0);
    chk("reset_words", words_loaded, 32'd0);
    chk("reset_we", imem_we, 1'b0);
    chk("reset_addr", imem_addr, c_base);
    chk("reset_wdata", imem_wdata, 32'd0);
    chk("reset_ready_in_rst", byte_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", byte_ready, 1'b1);

    // Two-word frame, back-to-back bytes
    frame(16'd2, 32'h00500093, 32'h00108113, 1'b0, 8'h00);
    check_end("b2b", 1'b1, 2, 2);

    // Same frame with byte_valid toggling; reset out of RUN re-holds the core
    do_reset();
    frame(16'd2, 32'h00500093, 32'h00108113, 1'b1, 8'h00);
    check_end("gapped", 1'b1, 2, 2);

    // Corrupted checksum
    do_reset();
    frame(16'd1, 32'hDEADBEEF, 32'h0, 1'b0, 8'h01);
    check_end("bad_csum", 1'b0, 1, 1);

    // Length overflow: N = 1025
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    check_end("overflow", 1'b0, 0, 0);
    repeat (4) send_byte(8'h00, 1'b0);
    check_end("overflow_hold", 1'b0, 0, 0);

    // Empty frame, then extra bytes must be ignored
    do_reset();
    frame(16'd0, 32'h0, 32'h0, 1'b0, 8'h00);
    check_end("empty", 1'b1, 0, 0);
    repeat (3) send_byte(8'hFF, 1'b0);
    check_end("empty_hold", 1'b1, 0, 0);

    // Reset mid-load after 6 payload bytes of an N=3 frame
    do_reset();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    chk("partial_words", words_loaded, 32'd1);
    chk("partial_writes", 32'(n_writes - wr_start), 32'd1);
    do_reset();
    frame(16'd1, 32'h12345678, 32'h0, 1'b0, 8'h00);
    check_end("restart", 1'b1, 1, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the pipelined core.
- Accepts a framed little-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Writes each word into the instruction memory's write port.
- Holds the core in reset until a complete frame with a correct checksum has been loaded, then releases it.

Parameters:
- DATA_WIDTH, 32, instruction word width; only 32 is supported.
- ADDRESS_WIDTH, 32, width of the byte address presented to instruction memory.
- IMEM_DEPTH, 1024, instruction memory capacity in words; maximum legal frame length.
- BASE_ADDR, 0, byte address of the first loaded word.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- byte_valid  in  1  source presents a byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte; combinational from state, 0 while rst=1.
- imem_we  out  1  one-cycle instruction memory write strobe.
- imem_addr  out  ADDRESS_WIDTH  byte address of the write.
- imem_wdata  out  DATA_WIDTH  word to write.
- cpu_rst  out  1  reset to the core; active-high.
- done  out  1  load succeeded; core running.
- error  out  1  load failed: length overflow or bad checksum.
- words_loaded  out  16  count of words written so far.

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes (each word LSB first), then one CSUM byte.
- CSUM = XOR of both length bytes and all payload bytes.
- A byte is accepted in a cycle where byte_valid && byte_ready.
- Reset (clk edge with rst=1):
  - state=LEN_LO; imem_we=0; imem_addr=BASE_ADDR; imem_wdata=0.
  - cpu_rst=1; done=0; error=0; words_loaded=0.
  - Byte-lane counter=0; running XOR=0.
  - Memory contents are not cleared. Reset mid-load abandons the partial frame; the next byte after rst deasserts is treated as LEN_LO.
- States: LEN_LO, LEN_HI, DATA, CSUM, RUN, ERR.
  - byte_ready=1 in LEN_LO, LEN_HI, DATA and CSUM; 0 in RUN and ERR.
- Transitions, each taken on acceptance of a byte:
  - LEN_LO -> LEN_HI.
  - LEN_HI with N=0 -> CSUM.
  - LEN_HI with N>IMEM_DEPTH -> ERR. This is decided immediately; no payload is consumed.
  - LEN_HI otherwise -> DATA.
  - DATA: lane counter 0..3 wraps. On acceptance of lane 3:
    - The word {b3,b2,b1,b0} is registered.
    - In the next cycle: imem_we=1 for exactly one cycle, imem_addr=BASE_ADDR+4*words_loaded (pre-increment value), imem_wdata=word.
    - words_loaded increments in that same cycle.
    - If this was word N -> CSUM.
  - CSUM -> RUN if the byte equals the running XOR; otherwise -> ERR.
- Terminal states:
  - RUN and ERR are left only by rst.
  - In RUN: cpu_rst=0 and done=1, starting the cycle after the CSUM byte is accepted.
  - In ERR: cpu_rst=1 and error=1, starting the cycle after the offending byte is accepted.
- cpu_rst is a registered output and is 1 in every state except RUN.
- done and error are never both 1.
- When byte_valid=0, no state, counter or XOR change occurs. Gaps of any length between bytes are legal.
- Payload bytes have no backpressure: byte_ready stays 1 throughout DATA, including the write cycle. Back-to-back bytes at one per cycle are sustained.
- words_loaded never exceeds N. The address increment is computed in ADDRESS_WIDTH bits.
- Single-cycle rst asserted during RUN re-holds the core (cpu_rst=1 from the next edge) and restarts loading.

Test Plan:
- Load N=2 with words 0x00500093, 0x00108113, sent back-to-back, CSUM = XOR of all 10 bytes -> imem_we pulses twice: addr 0x0 data 0x00500093, then addr 0x4 data 0x00108113. The cycle after CSUM: cpu_rst=0, done=1, words_loaded=2.
- Same frame with byte_valid toggling 1/0 every cycle -> identical writes, addresses and final state. No write is duplicated or dropped.
- Frame N=1 with a corrupted CSUM (correct ^ 0x01) -> one write to addr 0x0, then error=1, done=0, cpu_rst stays 1, byte_ready=0.
- LEN bytes 0x01,0x04 (N=1025 > IMEM_DEPTH) -> ERR the cycle after LEN_HI. imem_we never asserts; error=1.
- N=0 with CSUM byte 0x00 -> no writes, done=1, cpu_rst=0. A subsequent byte_valid is ignored (byte_ready=0).
- Assert rst for one cycle after 6 payload bytes of an N=3 frame, then send a fresh N=1 frame -> words_loaded restarts at 0 and the write goes to BASE_ADDR. The pre-reset partial word is never written.
